// File: rtl/cp0_pkg.sv
// cp0_pkg: constants shared by the coprocessor-0 block and its timer.
//   - mfc0/mtc0 register indices
//   - SR / Cause field positions
//   - ExcCode values
//   - entry_epc(): resume address computed at handler entry
package cp0_pkg;

  // Register indices
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // SR fields
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LSB = 10;

  // Cause fields
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  // IP/IM are six bits wide; bit 5 of the field (register bit 15) carries TI
  localparam int IRQ_W      = 6;
  localparam int IRQ_TI_BIT = 5;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // EPC points at the branch when the faulting instruction sits in its delay
  // slot, so the branch is re-executed on return.
  function automatic logic [31:0] entry_epc(input logic [31:0] pc, input logic bd);
    return (pc & ~32'h3) - (bd ? 32'd4 : 32'd0);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare, and the sticky TI bit.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_count_we        mtc0 to Count this cycle (overrides the increment)
//   i_compare_we      mtc0 to Compare this cycle (clears TI, arms the match)
//   i_wdata           mtc0 data
//   o_count           current Count
//   o_compare         current Compare
//   o_ti              registered TI bit
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_armed;
  logic        r_ti;
  logic        w_match;

  // Compare against the pre-increment Count; until the first Compare write the
  // match is ignored so a reset value of 0 does not fire immediately.
  assign w_match = r_armed && (r_count == r_compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_armed   <= 1'b0;
      r_ti      <= 1'b0;
    end else begin
      r_count <= i_count_we ? i_wdata : r_count + 32'd1;
      if (i_compare_we) begin
        // A Compare write outranks a same-cycle match: TI ends clear.
        r_compare <= i_wdata;
        r_armed   <= 1'b1;
        r_ti      <= 1'b0;
      end else if (w_match) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_ext.sv
// cp0_ext: coprocessor 0 for the pipelined MIPS core.
// Holds SR, Cause, EPC, PRId, BadVAddr, Count, Compare; arbitrates interrupts
// and synchronous exceptions; drives handler entry / eret to the PC-select.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   we, wa, wdata    mtc0 write port
//   ra, rdata        mfc0 read port (combinational)
//   pc, bd           memory-stage PC and its delay-slot flag
//   exc_code         synchronous exception code (0 = none)
//   bad_vaddr        faulting address for AdEL/AdES
//   eret             eret in the memory stage
//   hw_int           level-sensitive external interrupts
//   exc_take         enter the handler this cycle
//   eret_take        return to epc this cycle
//   epc              current EPC
//   timer_irq        registered TI bit
//
// exc_take / eret_take contract: both are combinational from the same-cycle
// inputs and current state; the consumer redirects the PC in the cycle they
// are high, and CP0 state updates at the following edge. Entry always wins, so
// at most one of the two is high in any cycle.
module cp0_ext
  import cp0_pkg::*;
#(
  parameter int unsigned HW_IRQ_N = 6,
  parameter bit          TIMER_EN = 1'b1,
  parameter logic [31:0] PRID     = 32'h00330099
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [4:0]          wa,
  input  logic [31:0]         wdata,
  input  logic [4:0]          ra,
  output logic [31:0]         rdata,
  input  logic [31:0]         pc,
  input  logic                bd,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         bad_vaddr,
  input  logic                eret,
  input  logic [HW_IRQ_N-1:0] hw_int,
  output logic                exc_take,
  output logic                eret_take,
  output logic [31:0]         epc,
  output logic                timer_irq
);

  logic             r_ie;
  logic             r_exl;
  logic [IRQ_W-1:0] r_im;
  logic             r_bd;
  logic [4:0]       r_exccode;
  logic [31:0]      r_epc;
  logic [31:0]      r_badvaddr;

  logic [31:0]      w_count;
  logic [31:0]      w_compare;
  logic             w_ti;
  logic [IRQ_W-1:0] w_ip_live;
  logic             w_int_pend;
  logic             w_exc_pend;
  logic             w_capture_bva;
  logic [31:0]      w_sr;
  logic [31:0]      w_cause;
  logic             w_sr_we;
  logic             w_epc_we;

  // Timer
  generate
    if (TIMER_EN) begin : g_timer
      cp0_timer u_timer (
        .clk          (clk),
        .rst          (reset),
        .i_count_we   (we && (wa == REG_COUNT)),
        .i_compare_we (we && (wa == REG_COMPARE)),
        .i_wdata      (wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
      );
    end else begin : g_no_timer
      assign w_count   = '0;
      assign w_compare = '0;
      assign w_ti      = 1'b0;
    end
  endgenerate

  // Interrupt / exception arbitration
  // IP is not stored: it is the live view of the request lines, so the same
  // value feeds both the pending test and the Cause read.
  always_comb begin
    w_ip_live                 = '0;
    w_ip_live[HW_IRQ_N-1:0]   = hw_int;
    if (TIMER_EN) begin
      w_ip_live[IRQ_TI_BIT] = w_ip_live[IRQ_TI_BIT] | w_ti;
    end
  end

  assign w_int_pend = r_ie && !r_exl && |(w_ip_live & r_im);
  assign w_exc_pend = !r_exl && (exc_code != EXC_INT);
  assign exc_take   = w_int_pend || w_exc_pend;
  assign eret_take  = eret && !exc_take;

  assign w_capture_bva = !w_int_pend &&
                         ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES));
  assign w_sr_we  = we && (wa == REG_SR);
  assign w_epc_we = we && (wa == REG_EPC);

  // SR / Cause / EPC / BadVAddr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_im       <= '0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else if (exc_take) begin
      // Entry drops any same-cycle mtc0 to SR or EPC.
      r_exl     <= 1'b1;
      r_bd      <= bd;
      r_epc     <= entry_epc(pc, bd);
      r_exccode <= w_int_pend ? EXC_INT : exc_code;
      if (w_capture_bva) begin
        r_badvaddr <= bad_vaddr;
      end
    end else begin
      if (w_sr_we) begin
        r_ie  <= wdata[SR_IE];
        r_exl <= wdata[SR_EXL];
        r_im  <= wdata[SR_IM_LSB +: IRQ_W];
      end
      if (w_epc_we) begin
        r_epc <= wdata & ~32'h3;
      end
      // Placed after the SR write so a same-cycle eret still leaves EXL clear.
      if (eret_take) begin
        r_exl <= 1'b0;
      end
    end
  end

  // mfc0 read
  always_comb begin
    w_sr                         = '0;
    w_sr[SR_IE]                  = r_ie;
    w_sr[SR_EXL]                 = r_exl;
    w_sr[SR_IM_LSB +: IRQ_W]     = r_im;

    w_cause                      = '0;
    w_cause[CAUSE_BD]            = r_bd;
    w_cause[CAUSE_TI]            = w_ti;
    w_cause[CAUSE_IP_LSB +: IRQ_W] = w_ip_live;
    w_cause[CAUSE_EXC_LSB +: 5]  = r_exccode;
  end

  always_comb begin
    rdata = '0;
    case (ra)
      REG_BADVADDR: rdata = r_badvaddr;
      REG_COUNT:    rdata = w_count;
      REG_COMPARE:  rdata = w_compare;
      REG_SR:       rdata = w_sr;
      REG_CAUSE:    rdata = w_cause;
      REG_EPC:      rdata = r_epc;
      REG_PRID:     rdata = PRID;
      default:      rdata = '0;
    endcase
  end

  assign epc       = r_epc;
  assign timer_irq = w_ti;

endmodule

// File: tb/tb_cp0_ext.sv
// tb_cp0_ext: self-checking bench for cp0_ext (HW_IRQ_N=6, TIMER_EN=1).
module tb_cp0_ext;

  localparam logic [31:0] PRID_EXP = 32'h00330099;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wdata;
  logic [4:0]  ra;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic        exc_take;
  logic        eret_take;
  logic [31:0] epc;
  logic        timer_irq;

  cp0_ext #(
    .HW_IRQ_N (6),
    .TIMER_EN (1'b1),
    .PRID     (32'h00330099)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wa        (wa),
    .wdata     (wdata),
    .ra        (ra),
    .rdata     (rdata),
    .pc        (pc),
    .bd        (bd),
    .exc_code  (exc_code),
    .bad_vaddr (bad_vaddr),
    .eret      (eret),
    .hw_int    (hw_int),
    .exc_take  (exc_take),
    .eret_take (eret_take),
    .epc       (epc),
    .timer_irq (timer_irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural state as plain variables
  logic        m_ie, m_exl, m_bd, m_armed, m_ti;
  logic [5:0]  m_im;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bva, m_count, m_cmp;

  task automatic m_reset();
    m_ie = 0; m_exl = 0; m_bd = 0; m_armed = 0; m_ti = 0;
    m_im = 0; m_code = 0; m_epc = 0; m_bva = 0; m_count = 0; m_cmp = 0;
  endtask

  function automatic logic [5:0] m_ip();
    logic [5:0] ip;
    ip = hw_int;
    if (m_ti) ip[5] = 1'b1;
    return ip;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bva;
      5'd9:  return m_count;
      5'd11: return m_cmp;
      5'd12: return 32'(m_ie) + 32'(m_exl) * 2 + 32'(m_im) * 1024;
      5'd13: return 32'(m_bd) * 32'h8000_0000 + 32'(m_ti) * 32'h4000_0000 +
                    32'(m_ip()) * 1024 + 32'(m_code) * 4;
      5'd14: return m_epc;
      5'd15: return PRID_EXP;
      default: return 32'h0;
    endcase
  endfunction

  // Driver tasks. Called at the falling edge with inputs already applied;
  // outputs are compared 1 ns later, the model advances across the rising edge.
  task automatic set_idle();
    we = 0; wa = 0; wdata = 0; ra = 0; pc = 0; bd = 0;
    exc_code = 0; bad_vaddr = 0; eret = 0; hw_int = 0;
  endtask

  task automatic step();
    logic        intp, excp, take, et;
    logic        n_ie, n_exl, n_bd, n_armed, n_ti;
    logic [5:0]  n_im;
    logic [4:0]  n_code;
    logic [31:0] n_epc, n_bva, n_count, n_cmp;
    #1;
    intp = m_ie && !m_exl && ((m_ip() & m_im) != 0);
    excp = !m_exl && (exc_code != 0);
    take = intp || excp;
    et   = eret && !take;
    check("exc_take",  32'(exc_take),  32'(take));
    check("eret_take", 32'(eret_take), 32'(et));
    check("epc",       epc,            m_epc);
    check("timer_irq", 32'(timer_irq), 32'(m_ti));
    check("rdata",     rdata,          m_read(ra));

    n_ie = m_ie; n_exl = m_exl; n_bd = m_bd; n_armed = m_armed; n_ti = m_ti;
    n_im = m_im; n_code = m_code; n_epc = m_epc; n_bva = m_bva;
    n_count = (we && wa == 5'd9) ? wdata : m_count + 1;
    n_cmp = m_cmp;
    if (we && wa == 5'd11) begin
      n_cmp = wdata; n_ti = 0; n_armed = 1;
    end else if (m_armed && m_count == m_cmp) begin
      n_ti = 1;
    end
    if (take) begin
      n_exl  = 1;
      n_bd   = bd;
      n_epc  = (pc / 4) * 4 - (bd ? 32'd4 : 32'd0);
      n_code = intp ? 5'd0 : exc_code;
      if (!intp && (exc_code == 5'd4 || exc_code == 5'd5)) n_bva = bad_vaddr;
    end else begin
      if (we && wa == 5'd12) begin
        n_ie = wdata[0]; n_exl = wdata[1]; n_im = wdata[15:10];
      end
      if (we && wa == 5'd14) n_epc = (wdata / 4) * 4;
      if (et) n_exl = 0;
    end

    @(posedge clk);
    m_ie = n_ie; m_exl = n_exl; m_bd = n_bd; m_armed = n_armed; m_ti = n_ti;
    m_im = n_im; m_code = n_code; m_epc = n_epc; m_bva = n_bva;
    m_count = n_count; m_cmp = n_cmp;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    set_idle();
    we = 1; wa = a; wdata = d;
    step();
    we = 0;
  endtask

  // Reset-state read table
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tab[10];

  logic [4:0] codes[4];
  logic [4:0] regs[8];
  int waited;

  initial begin
    // Watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_tab[0] = '{5'd8,  32'h0};
    rd_tab[1] = '{5'd9,  32'h0};
    rd_tab[2] = '{5'd11, 32'h0};
    rd_tab[3] = '{5'd12, 32'h0};
    rd_tab[4] = '{5'd13, 32'h0};
    rd_tab[5] = '{5'd14, 32'h0};
    rd_tab[6] = '{5'd15, 32'h00330099};
    rd_tab[7] = '{5'd3,  32'h0};
    rd_tab[8] = '{5'd0,  32'h0};
    rd_tab[9] = '{5'd31, 32'h0};
    codes = '{5'd4, 5'd5, 5'd10, 5'd12};
    regs  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};

    reset = 1'b1;
    set_idle();
    m_reset();
    @(negedge clk);
    @(negedge clk);

    // Reads while reset is held
    for (int i = 0; i < 10; i++) begin
      ra = rd_tab[i].idx;
      #1;
      check($sformatf("reset_read_%0d", rd_tab[i].idx), rdata, rd_tab[i].exp);
    end
    check("reset_epc",       epc,             32'h0);
    check("reset_timer_irq", 32'(timer_irq),  32'h0);
    check("reset_exc_take",  32'(exc_take),   32'h0);
    check("reset_eret_take", 32'(eret_take),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    ra = 0;

    // Hardware interrupt 0
    wr(5'd12, 32'h0000_0401);
    set_idle();
    hw_int = 6'b000001;
    #1 check("irq_exc_take", 32'(exc_take), 32'h1);
    step();
    ra = 5'd13;
    #1 check("irq_cause", rdata, 32'h0000_0400);
    check("irq_exc_take_next", 32'(exc_take), 32'h0);
    ra = 5'd12;
    #1 check("irq_sr_exl", rdata, 32'h0000_0403);
    hw_int = 0; eret = 1;
    #1 check("irq_eret_take", 32'(eret_take), 32'h1);
    step();
    set_idle(); ra = 5'd12;
    #1 check("irq_sr_after_eret", rdata, 32'h0000_0401);
    wr(5'd12, 32'h0);

    // AdEL in a delay slot
    set_idle();
    exc_code = 5'd4; bd = 1; pc = 32'h3008; bad_vaddr = 32'h1001;
    #1 check("adel_exc_take", 32'(exc_take), 32'h1);
    step();
    set_idle();
    #1 check("adel_epc", epc, 32'h3004);
    ra = 5'd13;
    #1 check("adel_cause", rdata, 32'h8000_0010);
    ra = 5'd8;
    #1 check("adel_badvaddr", rdata, 32'h1001);
    eret = 1;
    step();

    // Timer match -> interrupt, then Compare write clears TI
    wr(5'd9, 32'd10);
    wr(5'd11, 32'd20);
    wr(5'd12, 32'h0000_8001);
    set_idle();
    waited = 0;
    while (!timer_irq && waited < 40) begin
      step();
      waited++;
    end
    check("timer_latency", 32'(waited), 32'd9);
    #1 check("timer_exc_take", 32'(exc_take), 32'h1);
    step();
    ra = 5'd13;
    #1 check("timer_cause", rdata, 32'h4000_8000);
    wr(5'd11, 32'd100);
    #1 check("timer_irq_cleared", 32'(timer_irq), 32'h0);
    set_idle(); eret = 1;
    step();
    wr(5'd12, 32'h0);

    // Exception beats a same-cycle eret
    set_idle();
    eret = 1; exc_code = 5'd12; pc = 32'h4000;
    #1 check("ov_exc_take", 32'(exc_take), 32'h1);
    check("ov_eret_take", 32'(eret_take), 32'h0);
    step();
    set_idle();
    #1 check("ov_epc", epc, 32'h4000);
    ra = 5'd13;
    #1 check("ov_cause", rdata, 32'h0000_0030);
    eret = 1;
    step();

    // Interrupt outranks RI; BadVAddr untouched
    wr(5'd12, 32'h0000_0401);
    set_idle();
    hw_int = 6'b000001; exc_code = 5'd10; bad_vaddr = 32'hdead; pc = 32'h6000;
    step();
    set_idle(); hw_int = 6'b000001; ra = 5'd13;
    #1 check("int_ri_cause", rdata, 32'h0000_0400);
    ra = 5'd8;
    #1 check("int_ri_badvaddr", rdata, 32'h1001);
    set_idle(); eret = 1;
    step();
    wr(5'd12, 32'h0);

    // Count wrap
    wr(5'd9, 32'hFFFF_FFFF);
    set_idle(); ra = 5'd9;
    #1 check("count_written", rdata, 32'hFFFF_FFFF);
    step();
    #1 check("count_wrapped", rdata, 32'h0);

    // Asynchronous reset mid-cycle
    set_idle();
    exc_code = 5'd12; pc = 32'h5554;
    step();
    set_idle();
    #1 check("pre_reset_epc", epc, 32'h5554);
    #1 reset = 1'b1;
    ra = 5'd12;
    #1 check("async_reset_epc", epc, 32'h0);
    check("async_reset_sr", rdata, 32'h0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_idle();
      we    = ($urandom_range(0, 3) == 0);
      wa    = ($urandom_range(0, 1) == 0) ? regs[$urandom_range(0, 7)] : 5'($urandom);
      wdata = $urandom;
      if (wa == 5'd11) wdata = m_count + 32'($urandom_range(0, 6));
      if (wa == 5'd12 && $urandom_range(0, 1) == 0) wdata = wdata & ~32'h2;
      exc_code  = ($urandom_range(0, 4) == 0) ? codes[$urandom_range(0, 3)] : 5'd0;
      eret      = ($urandom_range(0, 4) == 0);
      hw_int    = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
      bd        = 1'($urandom);
      pc        = $urandom;
      bad_vaddr = $urandom;
      ra        = 5'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_ext.md
# cp0_ext

Parametrised coprocessor-0 for the pipelined MIPS core: holds SR, Cause, EPC, PRId, BadVAddr, Count and Compare; arbitrates interrupts and synchronous exceptions; supplies the handler-entry and eret controls to the PC-select logic in the memory stage. Successor to the current CP0, adding:
- a configurable number of hardware interrupt lines;
- an internal Count/Compare timer with sticky pending bit;
- BadVAddr capture;
- an explicit eret handshake separate from exception entry.

## Interface
- HW_IRQ_N, 6, external interrupt lines, 1..6, mapped to IP[10 +: HW_IRQ_N]
- TIMER_EN, 1, instantiate timer; when 0, Count/Compare read 0 and TI never sets
- PRID, 32'h00330099, PRId read value
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- we  in  1  mtc0 write enable
- wa  in  5  mtc0 register index
- wdata  in  32  mtc0 data
- ra  in  5  mfc0 register index
- rdata  out  32  mfc0 data, combinational from ra
- pc  in  32  PC of the instruction in the memory stage
- bd  in  1  that instruction is in a branch delay slot
- exc_code  in  5  synchronous exception code, 0 = none
- bad_vaddr  in  32  faulting address for AdEL/AdES
- eret  in  1  eret in the memory stage
- hw_int  in  HW_IRQ_N  level-sensitive external interrupts
- exc_take  out  1  enter handler this cycle
- eret_take  out  1  return to epc this cycle
- epc  out  32  current EPC
- timer_irq  out  1  registered TI bit

## Operation
- Register indices: BadVAddr 8 (read-only), Count 9, Compare 11, SR 12, Cause 13, EPC 14, PRId 15. Any other index reads 0; writes to it are ignored.
- SR fields: IE bit 0, EXL bit 1, IM bits 15:10; all other bits read 0.
- Cause fields: BD bit 31, TI bit 30, IP bits 15:10, ExcCode bits 6:2; only mtc0-writable field is none.
- IP is refreshed every cycle:
  - IP[10 +: HW_IRQ_N] = hw_int;
  - IP bit 15 is additionally ORed with TI when TIMER_EN;
  - unused IP bits read 0.
- int_pend = IE & !EXL & |(IP_live & IM), where IP_live is the same-cycle value.
- exc_pend = !EXL & (exc_code != 0).
- exc_take = int_pend | exc_pend.
- eret_take = eret & !exc_take.
- On an exc_take edge:
  - EXL <= 1;
  - BD <= bd;
  - EPC <= {pc[31:2],2'b0} - (bd ? 4 : 0);
  - ExcCode <= int_pend ? 0 : exc_code (interrupt outranks synchronous exception);
  - BadVAddr <= bad_vaddr, only when ExcCode is 4 or 5 and no interrupt.
- On an eret_take edge: EXL <= 0.
- mtc0 writes:
  - EPC: write {wdata[31:2],2'b0};
  - Compare: write wdata, clear TI, set armed.
- Timer, when TIMER_EN:
  - Count increments by 1 every cycle and wraps 0xFFFFFFFF→0;
  - armed is an internal flag cleared by reset and set by any Compare write;
  - TI sets at the edge where armed & Count == Compare (pre-increment value).
- Reset values: SR 0, Cause 0, EPC 0, BadVAddr 0, Count 0, Compare 0, armed 0.
- Outputs after reset: timer_irq 0, epc 0; exc_take and eret_take are 0 when exc_code = 0 and eret = 0.

## Timing
- exc_take and eret_take are combinational, valid in the same cycle as their inputs; state updates at the following clk edge.
- EXL is visible the cycle after entry, so exc_take deasserts then; exc_take is never high for two consecutive cycles for one event.
- Interrupt latency: hw_int high with IE=1, EXL=0, IM bit set → exc_take in the same cycle.
- Timer latency: match edge → timer_irq high next cycle → exc_take that cycle if unmasked.
- Simultaneous events:
  - exc_take beats eret; EPC captures the eret's own PC.
  - Exception entry beats an mtc0 to SR or EPC in the same cycle; the write is dropped.
  - mtc0 Count beats the increment.
  - A Compare write beats a same-cycle match; TI ends clear.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.

## Structure
- Shared package cp0_pkg holds:
  - register index constants;
  - SR/Cause bit positions;
  - ExcCode constants (Int 0, AdEL 4, AdES 5, RI 10, Ov 12).
- One sub-module, cp0_timer: Count, Compare, armed and TI, with write ports and timer_irq output; generated only when TIMER_EN.

## Test plan
- Reset, then read all indices → SR, Cause, EPC, Count and Compare read 0; PRId reads 32'h00330099; index 3 reads 0.
- SR=0x0000_0401, assert hw_int[0] → exc_take=1 that cycle; next cycle EXL=1, Cause=0x0000_0400, exc_take=0.
- exc_code=4, bd=1, pc=0x3008, bad_vaddr=0x1001 → EPC=0x3004, Cause[31]=1, ExcCode=4, BadVAddr=0x1001.
- Write Compare=20, SR=0x8001 → TI sets when Count equals 20, timer_irq high the next cycle, exc_take fires; a later write Compare=100 clears TI.
- Same cycle: eret=1 and exc_code=12 with EXL=0 → exc_take=1, eret_take=0, EPC=pc of the eret.
- Interrupt and exc_code=10 in the same cycle → ExcCode=0 and BadVAddr unchanged; Count writes 0xFFFFFFFF then wraps to 0 the next cycle.
